shared_key_sequencer: RTL and testbench

Control block in front of `shared_key_expansion`. It accepts a two-share masked master key from the host and starts the expansion core with a one-cycle enable pulse. It captures each two-share round key as the core's round counter advances and streams them to the cipher round logic through a 2-entry valid/ready buffer. Shares are only stored and forwarded, never recombined; the block contains no XOR across share 0 and share 1.

---
 rtl/shared_key_sequencer_if.sv | 41 ++++
 rtl/shared_key_sequencer.sv | 136 +++++++++++++
 tb/tb_shared_key_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_key_sequencer_if.sv
// Host key load, expansion-core control and round-key stream of shared_key_sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface shared_key_sequencer_if #(
  parameter int unsigned CW = 5
);
  logic           key_valid;
  logic           key_ready;
  logic [127:0]   key0;
  logic [127:0]   key1;
  logic           blk_start;
  logic           kx_ena;
  logic [127:0]   kx_mkey0;
  logic [127:0]   kx_mkey1;
  logic [127:0]   kx_rk0;
  logic [127:0]   kx_rk1;
  logic [CW-1:0]  kx_round_cnt;
  logic           kx_occupied;
  logic           rk_valid;
  logic           rk_ready;
  logic [127:0]   rk0;
  logic [127:0]   rk1;
  logic [CW-1:0]  rk_idx;
  logic           rk_last;
  logic           done;
  logic           err_ovf;
  logic           err_short;

  modport slave (
    input  key_valid, key0, key1, blk_start,
    input  kx_rk0, kx_rk1, kx_round_cnt, kx_occupied, rk_ready,
    output key_ready, kx_ena, kx_mkey0, kx_mkey1,
    output rk_valid, rk0, rk1, rk_idx, rk_last, done, err_ovf, err_short
  );

  modport master (
    output key_valid, key0, key1, blk_start,
    output kx_rk0, kx_rk1, kx_round_cnt, kx_occupied, rk_ready,
    input  key_ready, kx_ena, kx_mkey0, kx_mkey1,
    input  rk_valid, rk0, rk1, rk_idx, rk_last, done, err_ovf, err_short
  );
endinterface

// File: rtl/shared_key_sequencer.sv
// Loads a two-share master key, kicks the expansion core and streams each captured
// round key (shares kept separate, never recombined) through a 2-entry buffer.
module shared_key_sequencer #(
  parameter int unsigned NUM_RK = 17,
  parameter int unsigned CW     = 5
) (
  input logic                  clk,
  input logic                  rst,
  shared_key_sequencer_if.slave bus
);
  localparam int unsigned KW = 128;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, RUN} state_t;

  state_t         state, state_next;
  logic           key_loaded;
  logic [KW-1:0]  mkey0, mkey1;
  logic [CW-1:0]  cnt_prev, pushed;
  logic           key_ready_q, kx_ena_q, done_q, err_ovf_q, err_short_q;

  logic           v0, v1;
  logic [KW-1:0]  e0_rk0, e0_rk1, e1_rk0, e1_rk1;
  logic [CW-1:0]  e0_idx, e1_idx;
  logic           e0_last, e1_last;

  logic           idle_act, key_hs, blk_go, run_eval, capture, final_cap, short_run, pop;
  logic           new_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // WAIT_BUSY hands over to RUN in the same cycle the core reports busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (key_hs || blk_go) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY,
      RUN: begin
        if (final_cap || short_run) state_next = IDLE;
        else if (run_eval)          state_next = RUN;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    idle_act  = (state == IDLE) && key_ready_q;
    key_hs    = idle_act && bus.key_valid;
    blk_go    = idle_act && bus.blk_start && key_loaded;
    run_eval  = (state == RUN) || ((state == WAIT_BUSY) && bus.kx_occupied);
    capture   = run_eval && bus.kx_occupied && (bus.kx_round_cnt != cnt_prev);
    new_last  = (pushed == CW'(NUM_RK - 1));
    final_cap = capture && new_last;
    short_run = (state == RUN) && !bus.kx_occupied;
    pop       = v0 && bus.rk_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_loaded  <= 1'b0;
      mkey0       <= '0;
      mkey1       <= '0;
      cnt_prev    <= '1;
      pushed      <= '0;
      key_ready_q <= 1'b0;
      kx_ena_q    <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      key_ready_q <= (state_next == IDLE);
      kx_ena_q    <= (state_next == START);
      done_q      <= final_cap;
      if (key_hs) begin
        key_loaded  <= 1'b1;
        mkey0       <= bus.key0;
        mkey1       <= bus.key1;
        err_short_q <= 1'b0;
      end
      if (state == START) begin
        cnt_prev <= '1;
        pushed   <= '0;
      end
      if (capture) begin
        cnt_prev <= bus.kx_round_cnt;
        pushed   <= pushed + CW'(1);
      end
      if (short_run) err_short_q <= 1'b1;
    end
  end

  // Two-entry buffer with entry 0 as the head; a full push without a pop is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;  v1 <= 1'b0;
      e0_rk0 <= '0; e0_rk1 <= '0; e0_idx <= '0; e0_last <= 1'b0;
      e1_rk0 <= '0; e1_rk1 <= '0; e1_idx <= '0; e1_last <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (key_hs) err_ovf_q <= 1'b0;
      if (capture) begin
        if (!v0 || (pop && !v1)) begin
          e0_rk0 <= bus.kx_rk0; e0_rk1 <= bus.kx_rk1; e0_idx <= pushed; e0_last <= new_last;
          v0 <= 1'b1;
        end else if (!v1) begin
          e1_rk0 <= bus.kx_rk0; e1_rk1 <= bus.kx_rk1; e1_idx <= pushed; e1_last <= new_last;
          v1 <= 1'b1;
        end else if (pop) begin
          e0_rk0 <= e1_rk0; e0_rk1 <= e1_rk1; e0_idx <= e1_idx; e0_last <= e1_last;
          e1_rk0 <= bus.kx_rk0; e1_rk1 <= bus.kx_rk1; e1_idx <= pushed; e1_last <= new_last;
        end else begin
          err_ovf_q <= 1'b1;
        end
      end else if (pop) begin
        e0_rk0 <= e1_rk0; e0_rk1 <= e1_rk1; e0_idx <= e1_idx; e0_last <= e1_last;
        v0 <= v1;
        v1 <= 1'b0;
      end
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.kx_ena    = kx_ena_q;
  assign bus.kx_mkey0  = mkey0;
  assign bus.kx_mkey1  = mkey1;
  assign bus.rk_valid  = v0;
  assign bus.rk0       = e0_rk0;
  assign bus.rk1       = e0_rk1;
  assign bus.rk_idx    = e0_idx;
  assign bus.rk_last   = e0_last;
  assign bus.done      = done_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_short = err_short_q;
endmodule

// File: tb/tb_shared_key_sequencer.sv
// Directed bench for shared_key_sequencer with a behavioural expansion core and a
// scoreboard of expected round keys (share XOR) popped on every accepted beat.
module tb_shared_key_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_key_sequencer_if #(.CW(5)) bus ();

  shared_key_sequencer #(.NUM_RK(17), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [4:0]   idx;
    logic [127:0] rk;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk, n_fail;
  int   ena_cnt, done_cnt, beats;
  int   abort_after;

  // Linear stand-in schedule: byte rotation per round, round constant on share 0 only.
  function automatic logic [127:0] rotl8(input logic [127:0] k, input logic [4:0] r);
    int s;
    s = (8 * int'(r)) % 128;
    if (s == 0) return k;
    return (k << s) | (k >> (128 - s));
  endfunction

  function automatic logic [127:0] rcon(input logic [4:0] r);
    return {8'(r) ^ 8'h5a, 112'h0, 3'b000, r};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] k, input logic [4:0] r);
    return rotl8(k, r) ^ rcon(r);
  endfunction

  // Core model: starts on kx_ena, holds each round count for two cycles.
  logic         core_busy = 1'b0;
  logic [4:0]   core_rnd  = 5'd0;
  logic         core_sub  = 1'b0;
  logic [127:0] cm0 = '0, cm1 = '0;

  always @(posedge clk) begin
    if (bus.kx_ena) begin
      core_busy <= 1'b1; core_rnd <= 5'd0; core_sub <= 1'b0;
      cm0 <= bus.kx_mkey0; cm1 <= bus.kx_mkey1;
    end else if (core_busy) begin
      if (core_sub) begin
        core_sub <= 1'b0;
        if (core_rnd == 5'd16 || (abort_after > 0 && int'(core_rnd) == abort_after - 1))
          core_busy <= 1'b0;
        else
          core_rnd <= core_rnd + 5'd1;
      end else begin
        core_sub <= 1'b1;
      end
    end
  end

  assign bus.kx_occupied  = core_busy;
  assign bus.kx_round_cnt = core_rnd;
  assign bus.kx_rk0       = rotl8(cm0, core_rnd) ^ rcon(core_rnd);
  assign bus.kx_rk1       = rotl8(cm1, core_rnd);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample the cycle about to be clocked, then advance to the next falling edge.
  task automatic tick();
    if (bus.kx_ena === 1'b1) ena_cnt++;
    if (bus.done === 1'b1)   done_cnt++;
    if (bus.rk_valid === 1'b1 && bus.rk_ready === 1'b1) begin
      beats++;
      check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rk_idx",  128'(bus.rk_idx), 128'(e.idx));
        check("rk_xor",  bus.rk0 ^ bus.rk1, e.rk);
        check("rk_last", 128'(bus.rk_last), 128'(e.last));
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_counts();
    ena_cnt = 0; done_cnt = 0; beats = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 128'({bus.key_ready, bus.kx_ena, bus.rk_valid, bus.rk_last,
                                 bus.done, bus.err_ovf, bus.err_short}), 128'(0));
    check({tag, "_data"}, bus.rk0 | bus.rk1 | bus.kx_mkey0 | bus.kx_mkey1, 128'(0));
    check({tag, "_idx"}, 128'(bus.rk_idx), 128'(0));
  endtask

  task automatic push_run(input logic [127:0] k, input int n);
    for (int r = 0; r < n; r++) begin
      exp_t e;
      e.idx  = 5'(r);
      e.rk   = ref_rk(k, 5'(r));
      e.last = (r == 16);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_key(input logic [127:0] s0, input logic [127:0] s1, input logic with_blk);
    clear_counts();
    bus.key0 = s0; bus.key1 = s1; bus.key_valid = 1'b1; bus.blk_start = with_blk;
    check("key_ready_hs", 128'(bus.key_ready), 128'(1));
    tick();
    bus.key_valid = 1'b0; bus.blk_start = 1'b0;
    check("kx_ena_t1", 128'(bus.kx_ena), 128'(1));
    check("kx_mkey0",  bus.kx_mkey0, s0);
    check("kx_mkey1",  bus.kx_mkey1, s1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 128'(done_cnt != 0), 128'(1));
  endtask

  task automatic check_run(input int n_exp);
    repeat (8) tick();
    check("ena_single",  128'(ena_cnt), 128'(1));
    check("done_single", 128'(done_cnt), 128'(1));
    check("beat_count",  128'(beats), 128'(n_exp));
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    check("key_ready_end", 128'(bus.key_ready), 128'(1));
  endtask

  logic [127:0] k_a, k_c, k_d, r1;
  int n;

  initial begin
    n_chk = 0; n_fail = 0; abort_after = -1;
    clear_counts();
    k_a = 128'h0123456789abcdeffedcba9876543210;
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.blk_start = 1'b0; bus.rk_ready = 1'b1;
    bus.key0 = '0; bus.key1 = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_zero("reset");
      tick();
    end
    rst = 1'b0;
    check_zero("post_reset");
    tick();
    check("key_ready_up", 128'(bus.key_ready), 128'(1));

    // Plain key, share 1 zero.
    push_run(k_a, 17);
    load_key(k_a, '0, 1'b0);
    wait_done(200);
    check_run(17);

    // Same key re-split with a random share 1.
    r1 = {$urandom, $urandom, $urandom, $urandom};
    push_run(k_a, 17);
    load_key(k_a ^ r1, r1, 1'b0);
    wait_done(200);
    check_run(17);

    // Consumer stalled for the whole run: two entries held, overflow flagged.
    k_c = 128'hdeadbeef_00112233_44556677_8899aabb;
    r1  = {$urandom, $urandom, $urandom, $urandom};
    bus.rk_ready = 1'b0;
    push_run(k_c, 2);
    load_key(k_c ^ r1, r1, 1'b0);
    wait_done(200);
    tick(); tick();
    check("ovf_valid_held", 128'(bus.rk_valid), 128'(1));
    check("ovf_head_idx",   128'(bus.rk_idx), 128'(0));
    check("ovf_flag",       128'(bus.err_ovf), 128'(1));
    check("ovf_done",       128'(done_cnt), 128'(1));
    bus.rk_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 128'(beats), 128'(2));
    check("ovf_queue",   128'(exp_q.size()), 128'(0));
    push_run(k_c, 17);
    load_key(k_c, '0, 1'b0);
    check("ovf_cleared", 128'(bus.err_ovf), 128'(0));
    wait_done(200);
    check_run(17);

    // Core drops busy after five rounds.
    abort_after = 5;
    push_run(k_a, 5);
    load_key(k_a, '0, 1'b0);
    n = 0;
    while (bus.err_short !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("short_flag",  128'(bus.err_short), 128'(1));
    check("short_idle",  128'(bus.key_ready), 128'(1));
    repeat (4) tick();
    check("short_nodone", 128'(done_cnt), 128'(0));
    check("short_beats",  128'(beats), 128'(5));
    abort_after = -1;
    clear_counts();
    push_run(k_a, 17);
    bus.blk_start = 1'b1;
    tick();
    bus.blk_start = 1'b0;
    check("blk_kx_ena", 128'(bus.kx_ena), 128'(1));
    wait_done(200);
    check_run(17);
    check("short_sticky", 128'(bus.err_short), 128'(1));

    // blk_start with no key stored is ignored.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    clear_counts();
    bus.blk_start = 1'b1;
    tick();
    bus.blk_start = 1'b0;
    repeat (6) tick();
    check("noload_ena",   128'(ena_cnt), 128'(0));
    check("noload_ready", 128'(bus.key_ready), 128'(1));

    // Key handshake and blk_start together: new key, one start pulse.
    k_d = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    r1  = {$urandom, $urandom, $urandom, $urandom};
    push_run(k_d, 17);
    load_key(k_d ^ r1, r1, 1'b1);
    wait_done(200);
    check_run(17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
